serial_parity_rx: RTL
=====================

SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter: DATA_W, default 8, data bits per frame (1..16).
REQ-002 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit (even, >=4).
REQ-003 Parameter: PARITY_ODD, default 0; 0 means even parity (EVEN=0), 1 means odd parity (ODD=1).
REQ-004 Port: clock  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in  input  1  serial line; idle high; already synchronised to clock upstream.
REQ-007 Port: data_out  output  DATA_W  data of the last completed frame, LSB received first.
REQ-008 Port: valid  output  1  one-cycle pulse per completed frame.
REQ-009 Port: parity_err  output  1  parity status of the last completed frame.
REQ-010 Port: frame_err  output  1  stop-bit status of the last completed frame.
REQ-011 Port: err_count  output  8  error count; see Configuration.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 In IDLE, in=0 SHALL move the FSM to START and clear the bit timer.
REQ-015 In START, in SHALL be sampled at timer count CLKS_PER_BIT/2-1; in=1 SHALL return to IDLE (false start, no valid), and in=0 SHALL go to DATA.
REQ-016 Sampling SHALL continue every CLKS_PER_BIT cycles after the start sample, at mid-bit.
REQ-017 In DATA, each sample SHALL shift into a DATA_W shift register and toggle a running parity bit when the sample is 1; after DATA_W samples the FSM SHALL go to PARITY.
REQ-018 The running parity SHALL be cleared on entry to START.
REQ-019 In PARITY, the sampled bit SHALL be XORed into the running parity; mismatch = result != PARITY_ODD.
REQ-020 In STOP, on the stop sample, data_out, parity_err (the mismatch) and frame_err (sample==0) SHALL be registered, and valid SHALL pulse high in the next cycle.
REQ-021 After STOP, the FSM SHALL go to IDLE if the stop sample is 1, otherwise to WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL hold until in=1 for one sample clock, then go to IDLE; no start is detected while in WAIT_IDLE.
REQ-023 data_out, parity_err and frame_err SHALL hold their values until the next frame completes.
REQ-024 valid SHALL never be high for two consecutive cycles.
REQ-025 A frame with both errors SHALL assert both flags in the same valid pulse.

Reset
REQ-026 reset_n low SHALL immediately force the FSM to IDLE and set data_out=0, valid=0, parity_err=0, frame_err=0, err_count=0, and the timer, bit index and running parity to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame and produce no valid pulse; reception SHALL resume on the first start bit after release.

Configuration
REQ-028 Macro SERIAL_RX_ERR_CNT_EN defined: err_count SHALL increment by 1 on each valid pulse with parity_err or frame_err set, saturating at 255; it is cleared only by reset.
REQ-029 Macro SERIAL_RX_ERR_CNT_EN undefined: err_count SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-030 Package serial_rx_pkg SHALL hold the FSM state typedef and the EVEN/ODD parity constants.
REQ-031 Sub-module bit_timer SHALL provide the CLKS_PER_BIT counter and a mid-bit sample strobe, with clear and enable inputs.

Verification
REQ-032 Test: DATA_W=8, CLKS_PER_BIT=4, even parity; send 0xA5 with parity 0 and stop 1 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
REQ-033 Test: send 0xA5 with parity 1 -> valid, data_out=0xA5, parity_err=1; with the macro defined, err_count=1.
REQ-034 Test: send 0x3C with stop bit 0 and hold in=0 for 20 cycles -> frame_err=1 and no second frame; the next frame 0x01 after in returns high -> data_out=0x01, frame_err=0.
REQ-035 Test: pulse in low for 1 cycle only -> no valid and FSM back in IDLE; the following frame 0xFF (parity 0) is received correctly.
REQ-036 Test: assert reset_n low during data bit 4 of a frame -> all outputs 0 at once, no valid; the next frame 0x5A (parity 0) gives data_out=0x5A.
REQ-037 Test: with the macro defined, send 300 frames with parity errors -> err_count saturates at 255.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial parity receiver.
// Optional error counter is enabled with SERIAL_RX_ERR_CNT_EN.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_rx_bit_timer.sv
// Bit-period counter with a mid-bit sample strobe.
// Clear restarts the period; enable lets it run.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign strobe = enable && (cnt == MID);

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, LSB-first data, parity, stop.
// Define SERIAL_RX_ERR_CNT_EN to build the saturating error counter.
module serial_parity_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? ODD : EVEN;

  rx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              par;
  logic              par_bad;
  logic              strobe;
  logic              t_clear;
  logic              t_en;

  assign t_clear = (state == IDLE) && !in;
  assign t_en    = (state == START) || (state == DATA) ||
                   (state == PARITY) || (state == STOP);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (t_clear),
    .enable (t_en),
    .strobe (strobe)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      par        <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!in) begin
            state <= START;
            par   <= 1'b0;
          end
        end
        START: begin
          if (strobe) begin
            if (in) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (strobe) begin
            shreg <= (shreg >> 1) |
                     (DATA_W'(in) << (DATA_W - 1));
            par   <= par ^ in;
            if (bit_idx == IW'(DATA_W - 1)) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        PARITY: begin
          if (strobe) begin
            par_bad <= ((par ^ in) != PAR_MODE);
            state   <= STOP;
          end
        end
        STOP: begin
          if (strobe) begin
            data_out   <= shreg;
            parity_err <= par_bad;
            frame_err  <= !in;
            valid      <= 1'b1;
            state      <= in ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A broken stop bit leaves the line low; wait for it to recover.
          if (in) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'h00;
    end else if (valid && (parity_err || frame_err) &&
                 (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
